// File: rtl/alu_pkg.sv
// Shared encodings for the Y86 execute-stage ALU: opcodes, FSM states and CC reset value.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_XOR = 3'd3;
  localparam logic [2:0] OP_MUL = 3'd4;

  typedef enum logic [0:0] {S_IDLE, S_MUL} state_t;

  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } cc_t;

  localparam cc_t CC_RESET = '{zf: 1'b1, sf: 1'b0, of: 1'b0};

  // MUL is only a real operation when the multiplier is built.
  function automatic logic op_is_legal(logic [2:0] op, logic mul_en);
    return (op < OP_MUL) || ((op == OP_MUL) && mul_en);
  endfunction

endpackage

// File: rtl/mul_shift_add.sv
// Signed shift-add multiplier: one multiplier bit per cycle over WIDTH cycles on magnitudes,
// sign applied to the final accumulator.
module mul_shift_add
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   prod
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;
  logic [CW-1:0]      cnt_q;
  logic               neg_q;
  logic               active_q;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;

  // Magnitudes are unsigned, so the most-negative operand maps to 2^(WIDTH-1) without loss.
  always_comb begin
    mag_a = a[WIDTH-1] ? -a : a;
    mag_b = b[WIDTH-1] ? -b : b;
  end

  // One shift-add step; the last step is consumed combinationally through prod.
  always_comb begin
    acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
  end

  assign done = active_q && (cnt_q == CW'(WIDTH - 1));
  assign prod = neg_q ? -acc_d : acc_d;

  // Operand capture on start, then one iteration per cycle until the last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      active_q <= 1'b0;
    end else if (start) begin
      mcand_q  <= {{WIDTH{1'b0}}, mag_a};
      mplier_q <= mag_b;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= a[WIDTH-1] ^ b[WIDTH-1];
      active_q <= 1'b1;
    end else if (active_q) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CW'(1);
      if (done) begin
        active_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered Y86 execute-stage ALU with valid/ready handshake, multi-cycle MUL and CC register.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH  = 64,
  parameter bit          MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             set_cc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             ovf,
  output logic             illegal,
  output logic             cc_zf,
  output logic             cc_sf,
  output logic             cc_of,
  output logic             busy
);

  state_t state_q, state_d;
  cc_t    cc_q;
  logic   set_cc_q;

  logic   accept;
  logic   legal;
  logic   start_mul;

  logic [WIDTH-1:0]   alu_r;
  logic               alu_ovf;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;
  logic [WIDTH-1:0]   mul_r;
  logic               mul_ovf;

  logic             load;
  logic [WIDTH-1:0] load_r;
  logic             load_ovf;
  logic             load_ill;
  logic             load_cc;

  assign accept    = in_valid && in_ready;
  assign legal     = op_is_legal(op, MUL_EN);
  assign start_mul = accept && legal && (op == OP_MUL);

  // Single-cycle datapath; anything not handled here (illegal ops) yields zero.
  always_comb begin
    alu_r   = '0;
    alu_ovf = 1'b0;
    case (op)
      OP_ADD: begin
        alu_r   = b + a;
        alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (alu_r[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_r   = b - a;
        alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (alu_r[WIDTH-1] != b[WIDTH-1]);
      end
      OP_AND:  alu_r = a & b;
      OP_XOR:  alu_r = a ^ b;
      default: ;
    endcase
  end

  if (MUL_EN) begin : g_mul
    mul_shift_add #(
      .WIDTH (WIDTH)
    ) u_mul (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start_mul),
      .a     (a),
      .b     (b),
      .done  (mul_done),
      .prod  (mul_prod)
    );
  end else begin : g_no_mul
    assign mul_done = 1'b0;
    assign mul_prod = '0;
  end

  // Product overflows when its upper half is not the sign extension of the kept low half.
  assign mul_r   = mul_prod[WIDTH-1:0];
  assign mul_ovf = mul_prod[2*WIDTH-1:WIDTH] != {WIDTH{mul_prod[WIDTH-1]}};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: enter MUL on an accepted multiply, leave on the final iteration.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_mul) state_d = S_MUL;
      S_MUL:   if (mul_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: accept only when the output slot is free or draining this cycle.
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    case (state_q)
      S_IDLE:  in_ready = !out_valid || out_ready;
      S_MUL:   busy = 1'b1;
      default: ;
    endcase
  end

  // Select what, if anything, loads into the output register this cycle.
  always_comb begin
    load     = 1'b0;
    load_r   = alu_r;
    load_ovf = alu_ovf;
    load_ill = !legal;
    load_cc  = set_cc && legal;
    if (state_q == S_MUL) begin
      load     = mul_done;
      load_r   = mul_r;
      load_ovf = mul_ovf;
      load_ill = 1'b0;
      load_cc  = set_cc_q;
    end else if (accept && !start_mul) begin
      load = 1'b1;
    end
  end

  // Output register: hold while stalled, a load on a consume edge keeps out_valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      ovf       <= 1'b0;
      illegal   <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      result    <= load_r;
      ovf       <= load_ovf;
      illegal   <= load_ill;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // CC register and the set_cc flag held across a multiply.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cc_q     <= CC_RESET;
      set_cc_q <= 1'b0;
    end else begin
      if (start_mul) begin
        set_cc_q <= set_cc;
      end
      if (load && load_cc) begin
        cc_q <= '{zf: (load_r == '0), sf: load_r[WIDTH-1], of: load_ovf};
      end
    end
  end

  assign cc_zf = cc_q.zf;
  assign cc_sf = cc_q.sf;
  assign cc_of = cc_q.of;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: a 64-bit instance without MUL and an 8-bit instance with MUL, checked
// every cycle against a wide-arithmetic reference model, plus directed literal checks.
module tb_alu_seq;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0]  iv, sc, ordy;
  logic [2:0]  opv [2];
  logic [63:0] av [2];
  logic [63:0] bv [2];

  wire  [1:0]  ir, ov, ovf_v, ill_v, zf_v, sf_v, of_v, busy_v;
  wire  [63:0] res64;
  wire  [7:0]  res8;

  alu_seq #(.WIDTH(64), .MUL_EN(1'b0)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .op(opv[0]),
    .a(av[0]), .b(bv[0]), .set_cc(sc[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
    .result(res64), .ovf(ovf_v[0]), .illegal(ill_v[0]), .cc_zf(zf_v[0]), .cc_sf(sf_v[0]),
    .cc_of(of_v[0]), .busy(busy_v[0])
  );

  alu_seq #(.WIDTH(8), .MUL_EN(1'b1)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .op(opv[1]),
    .a(av[1][7:0]), .b(bv[1][7:0]), .set_cc(sc[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
    .result(res8), .ovf(ovf_v[1]), .illegal(ill_v[1]), .cc_zf(zf_v[1]), .cc_sf(sf_v[1]),
    .cc_of(of_v[1]), .busy(busy_v[1])
  );

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {
    logic [63:0] r;
    logic        ovf;
    logic        ill;
    logic        mul;
    int          load_edge;
    logic [2:0]  cc;
  } item_t;

  logic [1:0] have;
  item_t      slot [2];
  logic [2:0] cc_chain [2];
  logic [2:0] cc_vis [2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic signed [127:0] sext(input logic [63:0] x, input int w);
    logic [127:0] t;
    t = {64'b0, x} << (128 - w);
    return $signed(t) >>> (128 - w);
  endfunction

  // Exact result in 128 bits; overflow means it does not survive truncation to w bits.
  function automatic item_t model(input int w, input bit mul_en, input logic [2:0] o,
                                  input logic [63:0] x, input logic [63:0] y, input logic s,
                                  input logic [2:0] cc_in);
    logic signed [127:0] sa, sb, full;
    item_t it;
    sa = sext(x, w);
    sb = sext(y, w);
    it.ill = (o > 3'd4) || ((o == 3'd4) && !mul_en);
    it.mul = (o == 3'd4) && !it.ill;
    case (o)
      3'd0:    full = sb + sa;
      3'd1:    full = sb - sa;
      3'd2:    full = sa & sb;
      3'd3:    full = sa ^ sb;
      default: full = sa * sb;
    endcase
    if (it.ill) begin
      it.r   = '0;
      it.ovf = 1'b0;
    end else begin
      it.r   = (w == 64) ? full[63:0] : (full[63:0] & ((64'd1 << w) - 64'd1));
      it.ovf = (o == 3'd0 || o == 3'd1 || o == 3'd4) && (full != sext(it.r, w));
    end
    it.cc = (s && !it.ill) ? {it.r == 64'd0, it.r[w-1], it.ovf} : cc_in;
    it.load_edge = 0;
    return it;
  endfunction

  // Per-cycle comparison of both instances against the model.
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        have = '0;
        for (int g = 0; g < 2; g++) begin
          cc_chain[g] = 3'b100;
          cc_vis[g]   = 3'b100;
        end
      end else begin
        for (int g = 0; g < 2; g++) begin
          int w;
          logic ev, eb;
          logic [63:0] r;
          w  = (g == 0) ? 64 : 8;
          r  = (g == 0) ? res64 : {56'b0, res8};
          ev = have[g] && (slot[g].load_edge <= cyc);
          eb = have[g] && slot[g].mul && (slot[g].load_edge > cyc);
          if (have[g] && slot[g].load_edge == cyc) cc_vis[g] = slot[g].cc;
          chk($sformatf("out_valid[%0d]@%0d", g, cyc), ov[g], ev);
          chk($sformatf("busy[%0d]@%0d", g, cyc), busy_v[g], eb);
          chk($sformatf("in_ready[%0d]@%0d", g, cyc), ir[g], !eb && (!ev || ordy[g]));
          chk($sformatf("cc[%0d]@%0d", g, cyc), {zf_v[g], sf_v[g], of_v[g]}, cc_vis[g]);
          if (ev) begin
            chk($sformatf("result[%0d]@%0d", g, cyc), r, slot[g].r);
            chk($sformatf("ovf[%0d]@%0d", g, cyc), ovf_v[g], slot[g].ovf);
            chk($sformatf("illegal[%0d]@%0d", g, cyc), ill_v[g], slot[g].ill);
          end
          if (ov[g] && ordy[g]) have[g] = 1'b0;
          if (iv[g] && ir[g]) begin
            chk($sformatf("no_overwrite[%0d]@%0d", g, cyc), have[g], 1'b0);
            slot[g] = model(w, g == 1, opv[g], av[g], bv[g], sc[g], cc_chain[g]);
            slot[g].load_edge = cyc + 1 + (slot[g].mul ? w : 0);
            cc_chain[g] = slot[g].cc;
            have[g] = 1'b1;
          end
        end
      end
    end
  endtask

  // Present a request and hold it until the accepting edge; returns 1 ns after that edge.
  task automatic send(input int g, input logic [2:0] o, input logic [63:0] x,
                      input logic [63:0] y, input logic s);
    int n;
    n = 0;
    iv[g] = 1'b1; opv[g] = o; av[g] = x; bv[g] = y; sc[g] = s;
    @(negedge clk);
    while (!ir[g] && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("send_accept[%0d]", g), ir[g], 1'b1);
    @(posedge clk);
    #1;
    iv[g] = 1'b0;
  endtask

  function automatic logic [63:0] rand_val(input int w);
    case ($urandom % 8)
      0:       return 64'd0;
      1:       return '1;
      2:       return 64'd1 << (w - 1);
      3:       return (64'd1 << (w - 1)) - 64'd1;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  function automatic logic [2:0] rand_op();
    int k;
    k = $urandom % 10;
    if (k < 2) return 3'd0;
    if (k < 4) return 3'd1;
    if (k == 4) return 3'd2;
    if (k == 5) return 3'd3;
    if (k < 9) return 3'd4;
    return 3'($urandom_range(5, 7));
  endfunction

  task automatic driver(input int g, input int cycles);
    logic took;
    for (int n = 0; n < cycles; n++) begin
      @(negedge clk);
      took = iv[g] && ir[g];
      @(posedge clk);
      #1;
      if (!iv[g] || took) begin
        iv[g]  = ($urandom % 4) != 0;
        opv[g] = rand_op();
        av[g]  = rand_val(g == 0 ? 64 : 8);
        bv[g]  = rand_val(g == 0 ? 64 : 8);
        sc[g]  = 1'($urandom % 2);
      end
      ordy[g] = ($urandom % 4) != 0;
    end
    iv[g]   = 1'b0;
    ordy[g] = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1);
  end

  initial begin
    item_t t;
    int c1, c2, n;
    iv = '0; sc = '0; ordy = 2'b11;
    for (int g = 0; g < 2; g++) begin
      opv[g] = '0; av[g] = '0; bv[g] = '0;
    end
    fork
      monitor();
    join_none

    // Model pins against hand-computed values.
    t = model(8, 1, 3'd4, 64'hFD, 64'd7, 1'b1, 3'b100);
    chk("pin_mul_r", t.r, 64'hEB);
    chk("pin_mul_cc", t.cc, 3'b010);
    t = model(8, 1, 3'd4, 64'd16, 64'd16, 1'b1, 3'b000);
    chk("pin_mul_ovf", t.ovf, 1'b1);
    t = model(64, 0, 3'd1, 64'd1, 64'h8000_0000_0000_0000, 1'b1, 3'b100);
    chk("pin_sub_r", t.r, 64'h7FFF_FFFF_FFFF_FFFF);
    chk("pin_sub_cc", t.cc, 3'b001);

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_zf", zf_v[0], 1'b1);
    chk("rst_out_valid", ov[0], 1'b0);
    chk("rst_result", res64, 64'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", ir[0], 1'b1);

    // SUB overflow, visible right after the accepting edge.
    send(0, 3'd1, 64'd1, 64'h8000_0000_0000_0000, 1'b1);
    chk("sub_valid", ov[0], 1'b1);
    chk("sub_result", res64, 64'h7FFF_FFFF_FFFF_FFFF);
    chk("sub_ovf", ovf_v[0], 1'b1);
    chk("sub_cc", {zf_v[0], sf_v[0], of_v[0]}, 3'b001);

    // Back-to-back, then backpressure.
    send(0, 3'd0, 64'd5, 64'hFFFF_FFFF_FFFF_FFFB, 1'b1);
    c1 = cyc;
    chk("add_result", res64, 64'd0);
    chk("add_zf", zf_v[0], 1'b1);
    send(0, 3'd3, 64'hF0, 64'h0F, 1'b1);
    c2 = cyc;
    chk("b2b_gap", 64'(c2 - c1), 64'd1);
    chk("xor_result", res64, 64'hFF);
    chk("xor_cc", {zf_v[0], sf_v[0], of_v[0]}, 3'b000);
    ordy[0] = 1'b0;
    iv[0] = 1'b1; opv[0] = 3'd0; av[0] = 64'd1; bv[0] = 64'd2; sc[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("stall_result", res64, 64'hFF);
      chk("stall_valid", ov[0], 1'b1);
      chk("stall_in_ready", ir[0], 1'b0);
    end
    ordy[0] = 1'b1;
    send(0, 3'd0, 64'd1, 64'd2, 1'b0);
    chk("after_stall_result", res64, 64'd3);
    chk("after_stall_cc", {zf_v[0], sf_v[0], of_v[0]}, 3'b000);

    // Illegal ops leave CC alone; op 4 is illegal without MUL.
    send(0, 3'd6, 64'd123, 64'd456, 1'b1);
    chk("ill6_flag", ill_v[0], 1'b1);
    chk("ill6_result", res64, 64'd0);
    chk("ill6_cc", {zf_v[0], sf_v[0], of_v[0]}, 3'b000);
    send(0, 3'd4, 64'd3, 64'd5, 1'b1);
    chk("ill4_flag", ill_v[0], 1'b1);
    chk("ill4_result", res64, 64'd0);
    chk("ill4_ovf", ovf_v[0], 1'b0);
    chk("ill4_cc", {zf_v[0], sf_v[0], of_v[0]}, 3'b000);

    // Multiplies on the 8-bit instance.
    send(1, 3'd4, 64'hFD, 64'd7, 1'b1);
    chk("mul_busy", busy_v[1], 1'b1);
    chk("mul_in_ready", ir[1], 1'b0);
    n = 0;
    while (!ov[1] && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("mul_latency", 64'(n), 64'd8);
    chk("mul_m3x7", {56'b0, res8}, 64'hEB);
    chk("mul_m3x7_ovf", ovf_v[1], 1'b0);
    chk("mul_m3x7_cc", {zf_v[1], sf_v[1], of_v[1]}, 3'b010);
    send(1, 3'd4, 64'd16, 64'd16, 1'b1);
    repeat (8) @(posedge clk);
    #1;
    chk("mul_16x16", {56'b0, res8}, 64'h00);
    chk("mul_16x16_ovf", ovf_v[1], 1'b1);
    chk("mul_16x16_cc", {zf_v[1], sf_v[1], of_v[1]}, 3'b101);
    send(1, 3'd4, 64'h80, 64'd1, 1'b1);
    repeat (8) @(posedge clk);
    #1;
    chk("mul_min", {56'b0, res8}, 64'h80);
    chk("mul_min_ovf", ovf_v[1], 1'b0);
    send(1, 3'd7, 64'd9, 64'd9, 1'b1);
    chk("ill7_cc", {zf_v[1], sf_v[1], of_v[1]}, 3'b010);

    // Reset in the middle of a multiply.
    send(1, 3'd4, 64'd5, 64'd9, 1'b1);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy_v[1], 1'b0);
    chk("abort_valid", ov[1], 1'b0);
    chk("abort_result", {56'b0, res8}, 64'd0);
    chk("abort_cc", {zf_v[1], sf_v[1], of_v[1]}, 3'b100);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(1, 3'd0, 64'd3, 64'd4, 1'b1);
    chk("post_abort_add", {56'b0, res8}, 64'd7);
    chk("post_abort_cc", {zf_v[1], sf_v[1], of_v[1]}, 3'b000);

    // Randomized traffic on both instances.
    fork
      driver(0, 1500);
      driver(1, 1500);
    join
    repeat (20) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
